// File: rtl/wpg_pkg.sv
// Shared constants and helpers for the constant-weight pattern generator.
// Weight width and last-pattern mask are derived here so every file agrees on them.
package wpg_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Width needed to hold a popcount of a width-bit word (0..width inclusive).
    function automatic int weight_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Final word of a run: k ones packed against the MSB of a width-bit word.
    function automatic logic [15:0] top_mask(input int k, input int width);
        logic [31:0] ones;
        ones = (32'd1 << k) - 32'd1;
        return 16'(ones << (width - k));
    endfunction

endpackage

// File: rtl/gosper_next.sv
// Combinational successor: next larger word with the same popcount (Gosper's hack).
// Also reports the trailing-zero count of the input as a by-product of the priority encoder.
module gosper_next
    import wpg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CTZW  = weight_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next,
    output logic [CTZW-1:0]  ctz
);

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] low_bit;
    logic [WIDTH:0] ripple;

    // One guard bit above the word so the carry out of the top run is not lost.
    always_comb begin
        x_ext   = {1'b0, x};
        low_bit = x_ext & (-x_ext);
        ripple  = x_ext + low_bit;
    end

    // NOTE: every output of an always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        ctz = CTZW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                ctz = CTZW'(i);
            end
        end
    end

    // Shifting by ctz replaces the division by the lowest set bit.
    assign next = WIDTH'(ripple | (((ripple ^ x_ext) >> 2) >> ctz));

endmodule

// File: rtl/weight_pattern_gen.sv
// Streams every WIDTH-bit word of Hamming weight K in ascending order over valid/ready,
// with a running zero-based index and a last flag on the final word of the run.
module weight_pattern_gen
    import wpg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = weight_width(WIDTH),
    parameter int IW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CW-1:0]    weight_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             pat_valid_o,
    input  logic             pat_ready_i,
    output logic [WIDTH-1:0] pat_data_o,
    output logic             pat_last_o,
    output logic [IW-1:0]    pat_index_o
);

    localparam int             CTZW    = weight_width(WIDTH);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [IW-1:0]    index_q;
    logic [CW-1:0]    k_q;
    logic             err_q;

    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] start_mask;
    logic [CTZW-1:0]  ctz;
    logic             run;
    logic             handshake;
    logic             weight_ok;
    logic             at_last;

    gosper_next #(
        .WIDTH (WIDTH),
        .CTZW  (CTZW)
    ) u_next (
        .x    (data_q),
        .next (next_word),
        .ctz  (ctz)
    );

    always_comb begin
        first_word = WIDTH'((ONE_EXT << weight_i) - ONE_EXT);
        start_mask = WIDTH'(top_mask(int'(weight_i), WIDTH));
        weight_ok  = (weight_i <= CW'(WIDTH));
        run        = (state == ST_RUN);
        at_last    = (data_q == mask_q);
        handshake  = run & pat_ready_i;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            index_q <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (weight_ok) begin
                            state   <= ST_RUN;
                            data_q  <= first_word;
                            mask_q  <= start_mask;
                            index_q <= '0;
                            k_q     <= weight_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort wins over a same-cycle handshake; that word is dropped.
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if (handshake) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                        end else begin
                            data_q  <= next_word;
                            index_q <= index_q + IW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = run;
    assign err_o       = err_q;
    assign pat_valid_o = run;
    assign pat_data_o  = data_q;
    assign pat_last_o  = run & at_last;
    assign pat_index_o = index_q;

    // A weight-K word is the top-packed one exactly when its lowest one sits at WIDTH-K.
    last_matches_ctz: assert property (
        @(posedge clk) disable iff (!rst_n)
        pat_valid_o |-> (pat_last_o == ((int'(ctz) + int'(k_q)) == WIDTH))
    );

endmodule
